// File: rtl/dot_product_pkg.sv
// Shared types and sizing helpers for the dot-product sequencer and its MAC.
package dot_product_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    // Wide enough that 2**aw full-scale products can never overflow.
    function automatic int acc_width(input int dw, input int aw);
        return 2 * dw + aw + 1;
    endfunction

endpackage

// File: rtl/dot_product_if.sv
// Shared read port towards the operand RAM pair (A and B see the same address).
interface dot_product_if
    import dot_product_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    // Handshake: a rising edge with rd_en=1 issues rd_addr; a_data/b_data hold
    // the addressed words for the whole following cycle. No back-pressure.
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] a_data;
    logic [DATA_WIDTH-1:0] b_data;

    modport master (output rd_en, output rd_addr, input a_data, input b_data);
    modport slave  (input rd_en, input rd_addr, output a_data, output b_data);
endinterface

// File: rtl/dot_product_mac.sv
// Signed multiply-accumulate: clear has priority over enable.
module dot_product_mac
    import dot_product_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = acc_width(DEF_DATA_WIDTH, DEF_ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc_next
);
    logic [2*DATA_WIDTH-1:0] a_ext;
    logic [2*DATA_WIDTH-1:0] b_ext;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    prod_ext;
    logic [ACC_WIDTH-1:0]    acc_d;
    logic [ACC_WIDTH-1:0]    acc_q;

    // Sign-extending both operands first lets a plain unsigned multiply
    // produce the correct low 2*DATA_WIDTH bits of the signed product.
    assign a_ext    = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    assign b_ext    = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    assign acc_next = acc_q + prod_ext;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: sweeps the shared RAM address, accumulates A[k]*B[k]
// through the MAC and reports the sum with a one-cycle done pulse.
module dot_product_ctrl
    import dot_product_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [ADDR_WIDTH:0]         vec_len,
    dot_product_if.master               ram,
    output logic                        busy,
    output logic                        done,
    output logic signed [ACC_WIDTH-1:0] result,
    output state_e                      dbg_state
);
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ACC_WIDTH-1:0]  result_q, result_d;

    logic [ADDR_WIDTH:0]   n_sat;
    logic [ADDR_WIDTH:0]   n_sat_m1;
    logic                  mac_clear;
    logic                  mac_en;
    logic [ACC_WIDTH-1:0]  acc_next;

    assign n_sat    = (vec_len > MAX_LEN) ? MAX_LEN : vec_len;
    assign n_sat_m1 = n_sat - (ADDR_WIDTH+1)'(1);

    always_comb begin
        state_d   = state_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        last_d    = last_q;
        valid_d   = rd_en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        mac_clear = 1'b0;
        mac_en    = valid_q;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            rd_en_d = 1'b0;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            mac_en  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        busy_d    = 1'b1;
                        mac_clear = 1'b1;
                        rd_addr_d = '0;
                        if (n_sat == '0) begin
                            state_d  = ST_DONE;
                            done_d   = 1'b1;
                            result_d = '0;
                        end else begin
                            state_d = ST_READ;
                            rd_en_d = 1'b1;
                            last_d  = n_sat_m1[ADDR_WIDTH-1:0];
                        end
                    end
                end
                ST_READ: begin
                    // Stop on the stored last address rather than a wrap, so a
                    // full-length sweep ends cleanly on all-ones.
                    if (rd_addr_q == last_q) begin
                        state_d = ST_DRAIN;
                        rd_en_d = 1'b0;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (valid_q) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        result_d = acc_next;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            last_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    dot_product_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (mac_clear),
        .en       (mac_en),
        .a        (ram.a_data),
        .b        (ram.b_data),
        .acc_next (acc_next)
    );

    assign ram.rd_en   = rd_en_q;
    assign ram.rd_addr = rd_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_dot_product_ctrl.sv
// Scoreboard bench for dot_product_ctrl with a registered dual-RAM model.
module tb_dot_product_ctrl;
    import dot_product_pkg::*;

    localparam int AW   = DEF_ADDR_WIDTH;
    localparam int DW   = DEF_DATA_WIDTH;
    localparam int ACCW = acc_width(DW, AW);
    localparam int MAXN = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic [AW:0]            vec_len = '0;
    logic                   busy;
    logic                   done;
    logic signed [ACCW-1:0] result;
    state_e                 dbg_state;

    dot_product_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram ();

    dot_product_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (ACCW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .vec_len   (vec_len),
        .ram       (ram),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // Operand RAMs: data appears the cycle after the read edge.
    logic signed [DW-1:0] mem_a [MAXN];
    logic signed [DW-1:0] mem_b [MAXN];
    always @(posedge clk) begin
        if (ram.rd_en) begin
            ram.a_data <= mem_a[ram.rd_addr];
            ram.b_data <= mem_b[ram.rd_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [ACCW-1:0] exp_q[$];
    int              exp_lat_q[$];
    int              exp_len_q[$];
    logic [ACCW-1:0] exp_prev = '0;
    int              start_cyc = 0;
    int              op_seq = 0;
    bit              launched = 1'b0;
    int              n_checks = 0;
    int              n_pass = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    function automatic longint model_dot(input int n);
        longint s = 0;
        for (int k = 0; k < n; k++) s += longint'(mem_a[k]) * longint'(mem_b[k]);
        return s;
    endfunction

    // Monitor: address sweep, busy level and every done pulse.
    initial begin
        int seen_seq = 0;
        int rd_cnt = 0;
        logic [ACCW-1:0] e;
        int lat, len;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (seen_seq != op_seq) begin
                    seen_seq = op_seq;
                    rd_cnt = 0;
                end
                if (ram.rd_en) begin
                    check("rd_addr", longint'(ram.rd_addr), longint'(rd_cnt));
                    rd_cnt++;
                end
                if (launched && exp_q.size() != 0) check("busy_during_op", longint'(busy), 1);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e   = exp_q.pop_front();
                        lat = exp_lat_q.pop_front();
                        len = exp_len_q.pop_front();
                        check("result", longint'(result), longint'($signed(e)));
                        check("latency", longint'(cyc - start_cyc), longint'(lat));
                        check("rd_count", longint'(rd_cnt), longint'(len));
                        exp_prev = e;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input int n_req);
        int n_eff;
        n_eff = (n_req > MAXN) ? MAXN : n_req;
        @(negedge clk);
        launched = 1'b0;
        exp_q.push_back(ACCW'(model_dot(n_eff)));
        exp_lat_q.push_back((n_eff == 0) ? 0 : n_eff + 1);
        exp_len_q.push_back(n_eff);
        op_seq++;
        start   = 1'b1;
        vec_len = (AW+1)'(n_req);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
        launched  = 1'b1;
    endtask

    task automatic drop_pending();
        while (exp_q.size() != 0) begin
            void'(exp_q.pop_back());
            void'(exp_lat_q.pop_back());
            void'(exp_len_q.pop_back());
        end
        launched = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("done_timeout", 0, 1);
            drop_pending();
        end
        @(negedge clk);
        check("done_one_cycle", longint'(done), 0);
        check("busy_after_done", longint'(busy), 0);
        launched = 1'b0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < MAXN; k++) begin
            mem_a[k] = DW'($urandom);
            mem_b[k] = DW'($urandom);
        end
    endtask

    task automatic fill_basic();
        fill_random();
        for (int k = 0; k < 4; k++) begin
            mem_a[k] = DW'(k + 1);
            mem_b[k] = DW'(k + 5);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        fill_random();
        #1;
        check("reset_rd_en", longint'(ram.rd_en), 0);
        check("reset_rd_addr", longint'(ram.rd_addr), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        check("reset_result", longint'(result), 0);
        check("reset_state", longint'(dbg_state), longint'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic vector: expected 70 after N+1 cycles.
        fill_basic();
        start_op(4);
        wait_done();

        // Full length at most-negative operands: no address wrap.
        for (int k = 0; k < MAXN; k++) begin
            mem_a[k] = -8'sd128;
            mem_b[k] = -8'sd128;
        end
        start_op(16);
        wait_done();

        // Sign extension, then an empty vector.
        fill_random();
        mem_a[0] = 8'sd3;  mem_b[0] = -8'sd4;
        mem_a[1] = -8'sd2; mem_b[1] = 8'sd5;
        start_op(2);
        wait_done();
        start_op(0);
        wait_done();

        // Ignored re-start and abort mid-read.
        fill_basic();
        start_op(4);
        wait_done();
        fill_random();
        start_op(8);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drop_pending();
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_rd_en", longint'(ram.rd_en), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_state", longint'(dbg_state), longint'(ST_IDLE));
        check("abort_result_kept", longint'(result), longint'($signed(exp_prev)));
        repeat (12) @(negedge clk);

        // Abort and start in the same IDLE cycle: abort wins.
        start   = 1'b1;
        abort   = 1'b1;
        vec_len = 5'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", longint'(busy), 0);
        check("abort_start_rd_en", longint'(ram.rd_en), 0);
        repeat (8) @(negedge clk);

        // Saturated length, then reset mid-operation.
        fill_random();
        start_op(20);
        wait_done();
        start_op(12);
        repeat (5) @(posedge clk);
        #2;
        drop_pending();
        rst_n = 1'b0;
        #1;
        check("rst_mid_rd_en", longint'(ram.rd_en), 0);
        check("rst_mid_rd_addr", longint'(ram.rd_addr), 0);
        check("rst_mid_busy", longint'(busy), 0);
        check("rst_mid_done", longint'(done), 0);
        check("rst_mid_result", longint'(result), 0);
        exp_prev = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        fill_basic();
        start_op(4);
        wait_done();

        // Randomized lengths and operands.
        for (int it = 0; it < 12; it++) begin
            fill_random();
            start_op($urandom_range(0, 20));
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
